button_event_queue: RTL and testbench

- Sits downstream of the button state decoders and consumes their stretched up/down/short/long pulses for NUM_BTN buttons.
- Converts each pulse rising edge into one event word and queues it in a show-ahead FIFO.
- Presents the queue to the software register interface with a level interrupt and a sticky overflow flag, so the CPU never misses an event because of pulse timing.

---
 rtl/button_event_queue.sv | 122 ++++++++++++
 tb/tb_button_event_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Button event queue: turns rising edges of per-button down/up/short/long pulses
// into 8-bit event words, arbitrates them one per cycle into a show-ahead FIFO.
module button_event_queue #(
  parameter int NUM_BTN    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [NUM_BTN-1:0]            btn_down,
  input  logic [NUM_BTN-1:0]            btn_up,
  input  logic [NUM_BTN-1:0]            btn_shrt,
  input  logic [NUM_BTN-1:0]            btn_long,
  output logic                          evt_valid,
  output logic [7:0]                    evt_data,
  input  logic                          evt_rd,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          irq
);

  localparam int NSRC = 4 * NUM_BTN;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  // Source index 4*button+type is exactly the event word, so the encoder
  // output doubles as the FIFO write data.
  function automatic logic [7:0] first_set(input logic [NSRC-1:0] v);
    logic [7:0] idx;
    idx = 8'h00;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  function automatic logic [NSRC-1:0] lowest_bit(input logic [NSRC-1:0] v);
    return v & (~v + NSRC'(1));
  endfunction

  logic [NSRC-1:0] src_p0;
  logic [NSRC-1:0] src_p1;
  logic [NSRC-1:0] rise_p0;
  logic [NSRC-1:0] drop_p0;
  logic [NSRC-1:0] pend_p1;
  logic [NSRC-1:0] grant_p1;
  logic [7:0]      wr_data_p1;
  logic            wr_req_p1;
  logic            wr_acc_p1;
  logic            wr_rej_p1;
  logic            pop;
  logic            full;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_comb begin
    src_p0 = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      src_p0[4*b + 0] = btn_down[b];
      src_p0[4*b + 1] = btn_up[b];
      src_p0[4*b + 2] = btn_shrt[b];
      src_p0[4*b + 3] = btn_long[b];
    end
  end

  // Stage p0 -> p1: edge detect into pending bits
  assign rise_p0 = src_p0 & ~src_p1 & {NSRC{en}};
  assign drop_p0 = rise_p0 & pend_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_p1  <= '0;
      pend_p1 <= '0;
    end else begin
      src_p1  <= src_p0;
      pend_p1 <= (pend_p1 & ~grant_p1) | (rise_p0 & ~pend_p1);
    end
  end

  // Stage p1 -> FIFO: fixed-priority arbitration, one write per cycle
  assign grant_p1   = lowest_bit(pend_p1);
  assign wr_data_p1 = first_set(pend_p1);
  assign wr_req_p1  = |pend_p1;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = evt_rd & evt_valid;
  assign wr_acc_p1  = wr_req_p1 & (~full | pop);
  assign wr_rej_p1  = wr_req_p1 & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_acc_p1) mem[wr_ptr] <= wr_data_p1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc_p1) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc_p1, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new loss in the same cycle as a clear keeps the flag set.
      if ((|drop_p0) || wr_rej_p1) ovf <= 1'b1;
      else if (ovf_clr)            ovf <= 1'b0;
    end
  end

  assign evt_valid = (count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 8'h00;
  assign evt_count = count;
  assign irq       = evt_valid;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed self-checking bench for button_event_queue (NUM_BTN=4, FIFO_DEPTH=16).
module tb_button_event_queue;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [3:0] btn_down, btn_up, btn_shrt, btn_long;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_rd;
  logic [4:0] evt_count;
  logic       ovf;
  logic       ovf_clr;
  logic       irq;

  int total = 0;
  int bad   = 0;

  button_event_queue #(.NUM_BTN(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .btn_down(btn_down), .btn_up(btn_up), .btn_shrt(btn_shrt), .btn_long(btn_long),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_rd(evt_rd),
    .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", evt_valid); end
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", evt_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0h exp=0", ovf); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0h exp=0", irq); end
    total++; if (evt_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h exp=00", evt_data); end
    rstn = 1'b1;
    step(); step();
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL rst_idle_count got=%0d exp=0", evt_count); end
  endtask

  task automatic test_single();
    btn_down[2] = 1'b1;
    step();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0h exp=0", evt_valid); end
    step();
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", evt_valid); end
    total++; if (evt_data !== 8'h08) begin bad++; $display("FAIL single_data got=%0h exp=08", evt_data); end
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", evt_count); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%0h exp=1", irq); end
    repeat (8) step();
    btn_down[2] = 1'b0;
    step();
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL single_once got=%0d exp=1", evt_count); end
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0h exp=0", evt_valid); end
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", evt_count); end
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL empty_rd_count got=%0d exp=0", evt_count); end
  endtask

  task automatic test_simul();
    btn_long[0] = 1'b1; btn_down[0] = 1'b1; btn_up[3] = 1'b1;
    step();
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL simul_c0 got=%0d exp=0", evt_count); end
    step();
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL simul_c1 got=%0d exp=1", evt_count); end
    step();
    total++; if (evt_count !== 5'd2) begin bad++; $display("FAIL simul_c2 got=%0d exp=2", evt_count); end
    step();
    total++; if (evt_count !== 5'd3) begin bad++; $display("FAIL simul_c3 got=%0d exp=3", evt_count); end
    btn_long[0] = 1'b0; btn_down[0] = 1'b0; btn_up[3] = 1'b0;
    evt_rd = 1'b1;
    total++; if (evt_data !== 8'h00) begin bad++; $display("FAIL simul_d0 got=%0h exp=00", evt_data); end
    step();
    total++; if (evt_data !== 8'h03) begin bad++; $display("FAIL simul_d1 got=%0h exp=03", evt_data); end
    step();
    total++; if (evt_data !== 8'h0D) begin bad++; $display("FAIL simul_d2 got=%0h exp=0d", evt_data); end
    step();
    evt_rd = 1'b0;
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL simul_drain got=%0d exp=0", evt_count); end
  endtask

  task automatic test_overflow();
    btn_down = 4'hF; btn_up = 4'hF; btn_shrt = 4'hF; btn_long = 4'hF;
    repeat (17) step();
    total++; if (evt_count !== 5'd16) begin bad++; $display("FAIL ovf_fill_count got=%0d exp=16", evt_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill_flag got=%0h exp=0", ovf); end
    btn_down = 4'h0; btn_up = 4'h0; btn_shrt = 4'h0; btn_long = 4'h0;
    step();
    btn_down[0] = 1'b1;
    step(); step();
    total++; if (evt_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", evt_count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", ovf); end
    total++; if (evt_data !== 8'h00) begin bad++; $display("FAIL ovf_head got=%0h exp=00", evt_data); end
    btn_down[0] = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0h exp=0", ovf); end
    total++; if (evt_count !== 5'd16) begin bad++; $display("FAIL ovf_clr_count got=%0d exp=16", evt_count); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_d;
    btn_down[1] = 1'b1;
    step();
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    btn_down[1] = 1'b0;
    total++; if (evt_count !== 5'd16) begin bad++; $display("FAIL fullpop_count got=%0d exp=16", evt_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%0h exp=0", ovf); end
    evt_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 8'(i + 1) : 8'h04;
      total++; if (evt_data !== exp_d) begin bad++; $display("FAIL drain_%0d got=%0h exp=%0h", i, evt_data, exp_d); end
      step();
    end
    evt_rd = 1'b0;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h exp=0", evt_valid); end
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", evt_count); end
  endtask

  task automatic test_enable();
    en = 1'b0;
    btn_shrt[1] = 1'b1;
    repeat (3) step();
    en = 1'b1;
    repeat (3) step();
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL en_gate_count got=%0d exp=0", evt_count); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL en_gate_valid got=%0h exp=0", evt_valid); end
    btn_shrt[1] = 1'b0;
    step();
    btn_shrt[1] = 1'b1;
    step(); step();
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL en_valid got=%0h exp=1", evt_valid); end
    total++; if (evt_data !== 8'h06) begin bad++; $display("FAIL en_data got=%0h exp=06", evt_data); end
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL en_count got=%0d exp=1", evt_count); end
    btn_shrt[1] = 1'b0;
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL en_pop_count got=%0d exp=0", evt_count); end
  endtask

  task automatic test_mid_reset();
    btn_down = 4'b0011; btn_up = 4'b0011; btn_shrt = 4'b0001; btn_long = 4'b0001;
    step();
    btn_up[1] = 1'b0;
    step();
    btn_up[1] = 1'b1;
    repeat (4) step();
    total++; if (evt_count !== 5'd5) begin bad++; $display("FAIL mrst_pre_count got=%0d exp=5", evt_count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL mrst_pre_ovf got=%0h exp=1", ovf); end
    #1;
    rstn = 1'b0;
    btn_down = 4'b0000; btn_up = 4'b0010; btn_shrt = 4'b0000; btn_long = 4'b0000;
    #1;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0h exp=0", evt_valid); end
    total++; if (evt_count !== 5'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", evt_count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mrst_ovf got=%0h exp=0", ovf); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mrst_irq got=%0h exp=0", irq); end
    @(posedge clk);
    #3;
    rstn = 1'b1;
    step(); step();
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL mrst_post_count got=%0d exp=1", evt_count); end
    total++; if (evt_data !== 8'h05) begin bad++; $display("FAIL mrst_post_data got=%0h exp=05", evt_data); end
    repeat (3) step();
    total++; if (evt_count !== 5'd1) begin bad++; $display("FAIL mrst_once got=%0d exp=1", evt_count); end
    btn_up[1] = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; evt_rd = 1'b0; ovf_clr = 1'b0;
    btn_down = 4'h0; btn_up = 4'h0; btn_shrt = 4'h0; btn_long = 4'h0;
    test_reset();
    test_single();
    test_simul();
    test_overflow();
    test_full_pop();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
